// File: rtl/hram_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of the high-RAM macro (FF80-FFFE).
// Each access runs GRANT -> PCH (PCH_CYCLES) -> ACC -> DONE; out-of-range addresses end at GRANT with err.
module hram_arbiter #(
    parameter int PCH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    output logic       cpu_err,
    input  logic       dma_req,
    input  logic       dma_we,
    input  logic [7:0] dma_addr,
    input  logic [7:0] dma_wdata,
    output logic       dma_ack,
    output logic [7:0] dma_rdata,
    output logic       dma_err,
    output logic       hram_rd,
    output logic       hram_wr,
    output logic [7:0] hram_a,
    output logic [7:0] hram_dout,
    output logic       hram_doe,
    input  logic [7:0] hram_din,
    output logic       busy
);
    // state | meaning
    // IDLE  | no access in flight, arbitrate pending requests
    // GRANT | winner latched, address range check
    // PCH   | precharge, PCH_CYCLES cycles, no strobes
    // ACC   | single strobe cycle, read data captured at its end
    // DONE  | ack pulse to the granted port
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GRANT = 3'd1;
    localparam logic [2:0] ST_PCH   = 3'd2;
    localparam logic [2:0] ST_ACC   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic       PORT_CPU = 1'b0;
    localparam logic       PORT_DMA = 1'b1;
    localparam logic [1:0] PCH_LOAD = 2'(PCH_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic       last_q, last_d;
    logic       gnt_q, gnt_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [1:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;
    logic [7:0] dma_rdata_q, dma_rdata_d;
    logic       addr_legal;

    assign addr_legal = addr_q[7] && (addr_q != 8'hFF);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    // On a tie the port that did not win last time goes first.
                    if (cpu_req && dma_req) gnt_d = ~last_q;
                    else                    gnt_d = dma_req ? PORT_DMA : PORT_CPU;
                    we_d    = (gnt_d == PORT_DMA) ? dma_we    : cpu_we;
                    addr_d  = (gnt_d == PORT_DMA) ? dma_addr  : cpu_addr;
                    wdata_d = (gnt_d == PORT_DMA) ? dma_wdata : cpu_wdata;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                last_d = gnt_q;
                if (addr_legal) begin
                    cnt_d   = PCH_LOAD;
                    state_d = ST_PCH;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PCH: begin
                if (cnt_q == 2'd0) state_d = ST_ACC;
                else               cnt_d   = cnt_q - 2'd1;
            end
            ST_ACC: begin
                if (!we_q) begin
                    if (gnt_q == PORT_DMA) dma_rdata_d = hram_din;
                    else                   cpu_rdata_d = hram_din;
                end
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= PORT_DMA;
            gnt_q       <= PORT_CPU;
            we_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            cnt_q       <= 2'd0;
            err_q       <= 1'b0;
            cpu_rdata_q <= 8'h00;
            dma_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Strobes and acks decode straight from state so reset removes them without waiting for a clock.
    assign hram_rd   = (state_q == ST_ACC) && !we_q;
    assign hram_wr   = (state_q == ST_ACC) && we_q;
    assign hram_doe  = hram_wr;
    assign hram_a    = addr_q;
    assign hram_dout = wdata_q;
    assign cpu_ack   = (state_q == ST_DONE) && (gnt_q == PORT_CPU);
    assign dma_ack   = (state_q == ST_DONE) && (gnt_q == PORT_DMA);
    assign cpu_err   = err_q && (gnt_q == PORT_CPU);
    assign dma_err   = err_q && (gnt_q == PORT_DMA);
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign busy      = (state_q != ST_IDLE);
endmodule
